vga_timing: RTL
===============

Name: vga_timing

Overview:
Raster timing generator that sits directly upstream of the sprite/buffer renderers. It produces the raw pixel coordinates X_VGA/Y_VGA that every renderer compares against object positions. It also produces the VGA sync, blank and pixel-clock signals for the DAC. Coordinates are raw counter values that include sync and back porch, so the first visible pixel is at X=144, Y=35 for the default 640x480@60 timing.

Parameters:
H_SYNC, 96, horizontal sync width in pixels
H_BACK, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vertical sync width in lines
V_BACK, 33, vertical back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch
CLK_DIV, 2, CLK cycles per pixel; must be even and at least 2
SYNC_POL, 0, asserted level of VGA_HS/VGA_VS (0 = active low)

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  when low, freezes divider and counters
X_VGA  out  10  horizontal counter, 0..H_TOTAL-1
Y_VGA  out  10  vertical counter, 0..V_TOTAL-1
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
VGA_BLANK_N  out  1  high inside the visible area
VGA_SYNC_N  out  1  constant 0 (composite sync unused)
VGA_CLK  out  1  pixel clock to the DAC
pixel_tick  out  1  one-CLK strobe; counters advance on this cycle
line_start  out  1  one-CLK pulse when X wraps to 0
frame_start  out  1  one-CLK pulse when X and Y both wrap to 0

Behaviour:
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (default 800).
- V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT (default 525).
- All arithmetic is 10-bit unsigned. Totals must not exceed 1024; this is checked at elaboration.
- Divider div_cnt counts 0..CLK_DIV-1 and wraps to 0.
- pixel_tick is asserted in the cycle where div_cnt==CLK_DIV-1 and enable==1.
- On a pixel_tick:
  - If X==H_TOTAL-1, X becomes 0. Then Y becomes Y+1, or 0 if Y==V_TOTAL-1.
  - Otherwise X becomes X+1.
- Outputs are registered and mutually aligned: HS, VS, BLANK_N, line_start and frame_start describe the X/Y values visible in the same cycle. They are computed from the next-state counters.
- VGA_HS is asserted (equal to SYNC_POL) while X < H_SYNC.
- VGA_VS is asserted while Y < V_SYNC.
- VGA_BLANK_N is 1 when both of these hold:
  - H_SYNC+H_BACK <= X < H_SYNC+H_BACK+H_ACTIVE
  - V_SYNC+V_BACK <= Y < V_SYNC+V_BACK+V_ACTIVE
- line_start and frame_start are high for exactly one CLK cycle, the cycle in which the new (wrapped) X/Y first appears. frame_start implies line_start.
- VGA_CLK is 0 while div_cnt < CLK_DIV/2 and 1 otherwise. This gives a rising edge mid-pixel, and X/Y are stable on that edge.
- enable low: div_cnt, X, Y, HS, VS, BLANK_N and VGA_CLK all hold. pixel_tick, line_start and frame_start are 0. When enable returns high, counting resumes from the held state with no skipped pixel.
- Reset, including mid-frame: div_cnt=0, X=0, Y=0, VGA_HS=VGA_VS=SYNC_POL, VGA_BLANK_N=0, VGA_CLK=0, pixel_tick=0, line_start=0, frame_start=0, VGA_SYNC_N=0. Reset has priority over enable.
- First pixel_tick after reset release occurs CLK_DIV cycles later. It moves X to 1.

Decomposition:
- Shared package vga_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL, and the visible-origin constants X0=144 and Y0=35. Renderers use the same constants for their offsets.
- One natural sub-module, vga_axis_counter: a generic counter with parameters SYNC, BACK, ACTIVE and FRONT. Inputs are tick and enable. Outputs are count, wrap, sync and active.
- Instantiate vga_axis_counter twice. The vertical tick is the horizontal wrap ANDed with pixel_tick.

Test Plan:
1. Reset, then enable=1 for 2*800 CLK: X reaches 799 and returns to 0 with line_start=1 and Y=1. pixel_tick fires every 2nd CLK.
2. Horizontal sync and blank: VGA_HS=0 exactly for X in 0..95. On line Y=35, VGA_BLANK_N rises when X=144 and falls when X=784.
3. Full frame of 2*800*525 = 840000 CLK: frame_start pulses once, with X=0 and Y=0. VGA_VS=0 only for Y in 0..1. BLANK_N is 1 for exactly 640*480 = 307200 ticks.
4. Drop enable for 37 CLK at X=500, Y=200: all outputs hold, with no pixel_tick or line_start. After release, the next tick gives X=501.
5. Assert reset at X=300, Y=400: next cycle X=0, Y=0, HS=VS=0, BLANK_N=0, VGA_CLK=0. First tick comes 2 CLK after release.
6. Set SYNC_POL=1 and CLK_DIV=4: HS is high for X<96, pixel_tick fires every 4th CLK, and VGA_CLK is high for 2 of every 4 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared raster timing constants for the VGA timing generator and the
// sprite/buffer renderers downstream of it.
//   - Default 640x480@60 timing (sync, back porch, active, front porch).
//   - Derived line/frame totals.
//   - Visible-area origin X0/Y0. Coordinates are raw counter values that
//     include sync and back porch, so renderers offset object positions by
//     these constants.
//   - Coordinate type shared by the counters and the renderers.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;  // largest legal axis total

  typedef logic [COORD_W-1:0] coord_t;

  // Horizontal timing, in pixels.
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;

  // Vertical timing, in lines.
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;  // 800
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;  // 525

  // First visible pixel in raw counter coordinates.
  localparam int unsigned X0 = VGA_H_SYNC + VGA_H_BACK;  // 144
  localparam int unsigned Y0 = VGA_V_SYNC + VGA_V_BACK;  // 35

  // Pixel clock divider and sync polarity defaults.
  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam logic        VGA_SYNC_POL = 1'b0;  // active-low sync

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each
// enabled tick and wraps to 0. The sync/active flags are registered from the
// next-state count, so they always describe the count visible in the same
// cycle.
//
// Ports
//   clk_i     in   clock
//   reset_i   in   synchronous, active-high reset
//   enable_i  in   when low the counter and flags hold
//   tick_i    in   advance strobe
//   count_o   out  current count, 0..TOTAL-1
//   wrap_o    out  count is at TOTAL-1 (the next tick wraps it)
//   sync_o    out  count lies in the sync region, active high
//   active_o  out  count lies in the active (visible) region
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BACK   = VGA_H_BACK,
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FRONT  = VGA_H_FRONT
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   enable_i,
  input  logic   tick_i,
  output coord_t count_o,
  output logic   wrap_o,
  output logic   sync_o,
  output logic   active_o
);

  localparam int unsigned TOTAL = SYNC + BACK + ACTIVE + FRONT;

  if (TOTAL > COORD_MAX) begin : g_total_check
    $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, COORD_MAX);
  end

  // Region bounds carry one extra bit so an active region ending exactly at
  // COORD_MAX does not truncate to zero.
  typedef logic [COORD_W:0] coord_ext_t;

  localparam coord_t     LAST      = coord_t'(TOTAL - 1);
  localparam coord_ext_t SYNC_END  = coord_ext_t'(SYNC);
  localparam coord_ext_t ACT_BEGIN = coord_ext_t'(SYNC + BACK);
  localparam coord_ext_t ACT_END   = coord_ext_t'(SYNC + BACK + ACTIVE);

  // Flag values for count 0, loaded on reset.
  localparam logic SYNC_AT_0   = (SYNC != 0);
  localparam logic ACTIVE_AT_0 = (SYNC + BACK == 0) && (ACTIVE != 0);

  coord_t count_q, count_d;
  logic   sync_q, sync_d;
  logic   active_q, active_d;

  // NOTE: every signal gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    count_d = count_q;
    if (enable_i && tick_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
    end
    sync_d   = ({1'b0, count_d} < SYNC_END);
    active_d = ({1'b0, count_d} >= ACT_BEGIN) && ({1'b0, count_d} < ACT_END);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  // NOTE: reset is synchronous and covers every flop; there is no storage
  // array here that could be left unreset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= '0;
      sync_q   <= SYNC_AT_0;
      active_q <= ACTIVE_AT_0;
    end else begin
      count_q  <= count_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign count_o  = count_q;
  assign wrap_o   = (count_q == LAST);
  assign sync_o   = sync_q;
  assign active_o = active_q;

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Raster timing generator. Divides CLK into pixel periods, runs the X/Y raster
// counters and produces VGA sync, blank and pixel clock for the DAC. X/Y are
// raw counter values (sync and back porch included).
//
// Ports
//   CLK          in   system clock
//   reset        in   synchronous, active-high reset (wins over enable)
//   enable       in   low freezes the divider and counters
//   X_VGA        out  horizontal count, 0..H_TOTAL-1
//   Y_VGA        out  vertical count, 0..V_TOTAL-1
//   VGA_HS       out  horizontal sync, asserted level SYNC_POL
//   VGA_VS       out  vertical sync, asserted level SYNC_POL
//   VGA_BLANK_N  out  high inside the visible area
//   VGA_SYNC_N   out  constant 0 (no composite sync)
//   VGA_CLK      out  pixel clock, rising mid-pixel
//   pixel_tick   out  one-CLK strobe in the cycle whose edge advances X/Y
//   line_start   out  one-CLK pulse while the freshly wrapped X=0 is shown
//   frame_start  out  one-CLK pulse while the freshly wrapped X=0,Y=0 is shown
// -----------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BACK   = VGA_H_BACK,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT  = VGA_H_FRONT,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BACK   = VGA_V_BACK,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT  = VGA_V_FRONT,
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter logic        SYNC_POL = VGA_SYNC_POL
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               enable,
  output logic [COORD_W-1:0] X_VGA,
  output logic [COORD_W-1:0] Y_VGA,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               VGA_CLK,
  output logic               pixel_tick,
  output logic               line_start,
  output logic               frame_start
);

  if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_div_check
    $error("vga_timing: CLK_DIV=%0d must be even and at least 2", CLK_DIV);
  end

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_q, div_d;
  logic             vga_clk_q;
  logic             line_start_q;
  logic             frame_start_q;

  coord_t h_count, v_count;
  logic   h_wrap, v_wrap;
  logic   h_sync, v_sync;
  logic   h_active, v_active;
  logic   v_tick;

  // Pixel divider: the last phase of each pixel period carries the tick, and
  // the X/Y update happens on the edge that ends that phase.
  always_comb begin
    div_d = div_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  // Reset is gated in so the strobe never claims an advance that reset blocks.
  assign pixel_tick = enable && !reset && (div_q == DIV_LAST);
  assign v_tick     = pixel_tick && h_wrap;

  always_ff @(posedge CLK) begin
    if (reset) begin
      div_q         <= '0;
      vga_clk_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      // Registered from the next divider phase, so VGA_CLK tracks div_q and
      // rises halfway through the pixel while X/Y are stable.
      vga_clk_q     <= (div_d >= DIV_HALF);
      line_start_q  <= pixel_tick && h_wrap;
      frame_start_q <= pixel_tick && h_wrap && v_wrap;
    end
  end

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT)
  ) u_h_axis (
    .clk_i    (CLK),
    .reset_i  (reset),
    .enable_i (enable),
    .tick_i   (pixel_tick),
    .count_o  (h_count),
    .wrap_o   (h_wrap),
    .sync_o   (h_sync),
    .active_o (h_active)
  );

  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT)
  ) u_v_axis (
    .clk_i    (CLK),
    .reset_i  (reset),
    .enable_i (enable),
    .tick_i   (v_tick),
    .count_o  (v_count),
    .wrap_o   (v_wrap),
    .sync_o   (v_sync),
    .active_o (v_active)
  );

  assign X_VGA       = h_count;
  assign Y_VGA       = v_count;
  assign VGA_HS      = h_sync ? SYNC_POL : ~SYNC_POL;
  assign VGA_VS      = v_sync ? SYNC_POL : ~SYNC_POL;
  assign VGA_BLANK_N = h_active && v_active;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = vga_clk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
